// File: rtl/enc_quad_capture.sv
// Quadrature encoder front end: synchronise and glitch-filter A/B, decode x4 into
// independent forward/reverse counts, and snapshot both counts on CapCmd.
module enc_quad_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic        Clk,
    input  logic        RstN,
    input  logic        EncA,
    input  logic        EncB,
    input  logic        CapCmd,
    input  logic        ClrCmd,
    output logic [31:0] MemDataP,
    output logic [31:0] MemDataN,
    output logic        CapValid,
    output logic        Armed,
    output logic        ErrFlag
);

    localparam logic [3:0] FILT_LAST   = 4'(FILT_LEN - 1);
    localparam logic [4:0] SETTLE_LAST = 5'(SYNC_STAGES + FILT_LEN);

    typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILL} step_e;
    typedef enum logic       {ST_UNARMED, ST_ARMED} arm_state_e;

    // Forward order is 00->10->11->01->00 (bit1 = A, bit0 = B); any other single-bit move is reverse.
    function automatic step_e classify(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] fwd_next;
        case (prev)
            2'b00:   fwd_next = 2'b10;
            2'b10:   fwd_next = 2'b11;
            2'b11:   fwd_next = 2'b01;
            2'b01:   fwd_next = 2'b00;
            default: fwd_next = 2'b00;
        endcase
        if (cur == prev)          return STEP_NONE;
        else if (cur == fwd_next) return STEP_FWD;
        else if (cur == ~prev)    return STEP_ILL;
        else                      return STEP_REV;
    endfunction

    logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d, sync_b_q, sync_b_d;
    logic [1:0]             sync_lvl_s;
    logic [1:0]             filt_q, filt_d;
    logic [1:0][3:0]        fcnt_q, fcnt_d;
    logic [1:0]             prev_q, prev_d;
    logic [31:0]            fwd_q, fwd_d, rev_q, rev_d;
    logic                   err_q, err_d;
    logic [31:0]            mem_p_q, mem_p_d, mem_n_q, mem_n_d;
    logic                   cap_valid_q, cap_valid_d;
    step_e                  step_s;
    arm_state_e             state_q;
    logic [4:0]             settle_q;
    logic                   armed_q;

    // Synchroniser shift and glitch filter next-state.
    always_comb begin
        sync_a_d   = {sync_a_q[SYNC_STAGES-2:0], EncA};
        sync_b_d   = {sync_b_q[SYNC_STAGES-2:0], EncB};
        sync_lvl_s = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
        filt_d     = filt_q;
        fcnt_d     = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync_lvl_s[i] != filt_q[i]) begin
                if (fcnt_q[i] == FILT_LAST) begin
                    filt_d[i] = sync_lvl_s[i];
                    fcnt_d[i] = 4'd0;
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 4'd1;
                end
            end else begin
                fcnt_d[i] = 4'd0;
            end
        end
    end

    // Decoder, counters, error flag and capture next-state; clear wins over any event.
    always_comb begin
        step_s      = classify(prev_q, filt_q);
        prev_d      = filt_q;
        fwd_d       = fwd_q;
        rev_d       = rev_q;
        err_d       = err_q;
        if (ClrCmd) begin
            fwd_d = 32'd0;
            rev_d = 32'd0;
            err_d = 1'b0;
        end else if (armed_q) begin
            case (step_s)
                STEP_FWD: fwd_d = fwd_q + 32'd1;
                STEP_REV: rev_d = rev_q + 32'd1;
                STEP_ILL: err_d = 1'b1;
                default:  fwd_d = fwd_q;
            endcase
        end else begin
            fwd_d = fwd_q;
        end
        if (CapCmd) begin
            mem_p_d = fwd_q;
            mem_n_d = rev_q;
        end else begin
            mem_p_d = mem_p_q;
            mem_n_d = mem_n_q;
        end
        cap_valid_d = CapCmd;
    end

    // Datapath registers.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            sync_a_q    <= '0;
            sync_b_q    <= '0;
            filt_q      <= 2'b00;
            fcnt_q      <= '0;
            prev_q      <= 2'b00;
            fwd_q       <= 32'd0;
            rev_q       <= 32'd0;
            err_q       <= 1'b0;
            mem_p_q     <= 32'd0;
            mem_n_q     <= 32'd0;
            cap_valid_q <= 1'b0;
        end else begin
            sync_a_q    <= sync_a_d;
            sync_b_q    <= sync_b_d;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            prev_q      <= prev_d;
            fwd_q       <= fwd_d;
            rev_q       <= rev_d;
            err_q       <= err_d;
            mem_p_q     <= mem_p_d;
            mem_n_q     <= mem_n_d;
            cap_valid_q <= cap_valid_d;
        end
    end

    // Arming FSM: hold off decoding until the sync/filter pipeline has settled after reset.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q  <= ST_UNARMED;
            settle_q <= 5'd0;
            armed_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_UNARMED: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= ST_ARMED;
                        armed_q <= 1'b1;
                    end else begin
                        settle_q <= settle_q + 5'd1;
                        armed_q  <= 1'b0;
                    end
                end
                ST_ARMED: armed_q <= 1'b1;
                default: begin
                    state_q <= ST_UNARMED;
                    armed_q <= 1'b0;
                end
            endcase
        end
    end

    assign MemDataP = mem_p_q;
    assign MemDataN = mem_n_q;
    assign CapValid = cap_valid_q;
    assign Armed    = armed_q;
    assign ErrFlag  = err_q;

endmodule

// File: tb/tb_enc_quad_capture.sv
// Randomised scoreboard bench for enc_quad_capture: a level-based encoder model predicts
// the snapshot contents, and a monitor compares them whenever CapValid is seen.
module tb_enc_quad_capture;

    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 4;
    localparam int SETTLE      = SYNC_STAGES + FILT_LEN + 1;

    logic        Clk = 1'b0;
    logic        RstN = 1'b0;
    logic        EncA = 1'b0;
    logic        EncB = 1'b0;
    logic        CapCmd = 1'b0;
    logic        ClrCmd = 1'b0;
    logic [31:0] MemDataP, MemDataN;
    logic        CapValid, Armed, ErrFlag;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0]  seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0]  m_lvl = 2'b00;
    logic [31:0] m_fwd = 32'd0;
    logic [31:0] m_rev = 32'd0;
    logic        m_err = 1'b0;
    logic [63:0] exp_q [$];

    enc_quad_capture #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) dut (
        .Clk(Clk), .RstN(RstN), .EncA(EncA), .EncB(EncB), .CapCmd(CapCmd), .ClrCmd(ClrCmd),
        .MemDataP(MemDataP), .MemDataN(MemDataN), .CapValid(CapValid), .Armed(Armed),
        .ErrFlag(ErrFlag)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int pos(input logic [1:0] l);
        for (int i = 0; i < 4; i++) if (seq[i] == l) return i;
        return 0;
    endfunction

    // Encoder rule: one Gray step ahead is forward, one behind is reverse, opposite corner is illegal.
    function automatic void model_apply(input logic [1:0] nl);
        int idx = pos(m_lvl);
        if (nl != m_lvl) begin
            if (nl == seq[(idx + 1) % 4])      m_fwd = m_fwd + 32'd1;
            else if (nl == seq[(idx + 3) % 4]) m_rev = m_rev + 32'd1;
            else                               m_err = 1'b1;
        end
        m_lvl = nl;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic drive_level(input logic [1:0] lvl, input int hold);
        {EncA, EncB} = lvl;
        model_apply(lvl);
        idle(hold);
    endtask

    task automatic steps(input bit fwd, input int n);
        for (int i = 0; i < n; i++)
            drive_level(seq[(pos(m_lvl) + (fwd ? 1 : 3)) % 4], $urandom_range(FILT_LEN, 10));
    endtask

    task automatic glitch(input bit chan_a, input int len);
        logic [1:0] orig = m_lvl;
        logic [1:0] g    = chan_a ? (m_lvl ^ 2'b10) : (m_lvl ^ 2'b01);
        {EncA, EncB} = g;
        idle(len);
        {EncA, EncB} = orig;
        if (len >= FILT_LEN) begin
            model_apply(g);
            model_apply(orig);
        end
        idle(FILT_LEN + 2);
    endtask

    task automatic settle_check();
        idle(SETTLE + 4);
        chk("err_flag", {63'd0, ErrFlag}, {63'd0, m_err});
        chk("armed", {63'd0, Armed}, 64'd1);
    endtask

    task automatic capture(input int n, input bit clr);
        CapCmd = 1'b1;
        ClrCmd = clr;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({m_fwd, m_rev});
            @(negedge Clk);
            if (clr) begin
                m_fwd = 32'd0;
                m_rev = 32'd0;
                m_err = 1'b0;
            end
        end
        CapCmd = 1'b0;
        ClrCmd = 1'b0;
    endtask

    task automatic clear();
        ClrCmd = 1'b1;
        @(negedge Clk);
        ClrCmd = 1'b0;
        m_fwd = 32'd0;
        m_rev = 32'd0;
        m_err = 1'b0;
    endtask

    // Monitor: every CapValid pulse must match the oldest outstanding snapshot.
    always @(negedge Clk) begin
        if (RstN && CapValid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_capvalid", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("mem_data_p", {32'd0, MemDataP}, {32'd0, e[63:32]});
                chk("mem_data_n", {32'd0, MemDataN}, {32'd0, e[31:0]});
            end
        end
    end

    initial begin
        #1;
        chk("rst_mem_p", {32'd0, MemDataP}, 64'd0);
        chk("rst_mem_n", {32'd0, MemDataN}, 64'd0);
        chk("rst_capvalid", {63'd0, CapValid}, 64'd0);
        chk("rst_armed", {63'd0, Armed}, 64'd0);
        chk("rst_err", {63'd0, ErrFlag}, 64'd0);
        @(negedge Clk);
        RstN = 1'b1;
        // Capture while unarmed returns the zero counts.
        capture(1, 1'b0);
        settle_check();

        steps(1'b1, 8);
        settle_check();
        capture(1, 1'b0);
        idle(2);

        clear();
        steps(1'b0, 5);
        steps(1'b1, 3);
        settle_check();
        capture(1, 1'b0);

        glitch(1'b1, FILT_LEN - 1);
        glitch(1'b1, FILT_LEN);
        settle_check();
        capture(1, 1'b0);

        while (m_lvl != 2'b00) steps(1'b1, 1);
        settle_check();
        drive_level(2'b11, 10);
        settle_check();
        capture(1, 1'b0);
        clear();
        settle_check();
        capture(1, 1'b0);

        force dut.fwd_q = 32'hFFFF_FFFE;
        @(posedge Clk);
        #1 release dut.fwd_q;
        m_fwd = 32'hFFFF_FFFE;
        idle(2);
        steps(1'b1, 2);
        settle_check();
        capture(1, 1'b0);

        clear();
        steps(1'b1, 12);
        settle_check();
        capture(1, 1'b1);
        capture(1, 1'b0);
        steps(1'b0, 2);
        settle_check();
        capture(3, 1'b0);

        for (int op = 0; op < 40; op++) begin
            case ($urandom_range(0, 5))
                0:       steps(1'b1, $urandom_range(1, 6));
                1:       steps(1'b0, $urandom_range(1, 6));
                2:       glitch($urandom_range(0, 1) == 1, $urandom_range(1, FILT_LEN + 2));
                3:       drive_level(~m_lvl, 10);
                4:       begin idle(SETTLE + 4); clear(); end
                default: steps($urandom_range(0, 1) == 1, 1);
            endcase
            settle_check();
            if ($urandom_range(0, 2) != 0) capture($urandom_range(1, 2), $urandom_range(0, 4) == 0);
        end

        steps(1'b1, 3);
        settle_check();
        capture(1, 1'b0);
        idle(2);
        chk("pending_before_reset", 64'(exp_q.size()), 64'd0);
        drive_level(seq[(pos(m_lvl) + 1) % 4], 3);
        @(posedge Clk);
        #2 RstN = 1'b0;
        #1;
        chk("mid_rst_mem_p", {32'd0, MemDataP}, 64'd0);
        chk("mid_rst_mem_n", {32'd0, MemDataN}, 64'd0);
        chk("mid_rst_capvalid", {63'd0, CapValid}, 64'd0);
        chk("mid_rst_armed", {63'd0, Armed}, 64'd0);
        chk("mid_rst_err", {63'd0, ErrFlag}, 64'd0);
        {EncA, EncB} = 2'b11;
        m_lvl = 2'b11;
        m_fwd = 32'd0;
        m_rev = 32'd0;
        m_err = 1'b0;
        @(negedge Clk);
        RstN = 1'b1;
        for (int k = 1; k <= SETTLE + 1; k++) begin
            @(posedge Clk);
            #1 chk("arm_timing", {63'd0, Armed}, (k >= SETTLE) ? 64'd1 : 64'd0);
        end
        settle_check();
        capture(1, 1'b0);
        steps(1'b1, 2);
        settle_check();
        capture(1, 1'b0);
        idle(4);
        chk("pending_at_end", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
